// File: rtl/reflet_gpi_debouncer_pkg.sv
// Register map shared by the GPI debouncer RTL and the software header generator.
package reflet_gpi_debouncer_pkg;

  localparam int unsigned REG_COUNT = 8;

  localparam logic [2:0] PRESC_LO  = 3'd0;
  localparam logic [2:0] PRESC_HI  = 3'd1;
  localparam logic [2:0] THRESH    = 3'd2;
  localparam logic [2:0] BYPASS_LO = 3'd3;
  localparam logic [2:0] BYPASS_HI = 3'd4;
  localparam logic [2:0] SYNC_LO   = 3'd5;
  localparam logic [2:0] SYNC_HI   = 3'd6;

endpackage

// File: rtl/reflet_debounce_bit.sv
// Two-flop synchroniser plus tick-based stable-time filter for one pad input.
module reflet_debounce_bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad,
  input  logic       tick,
  input  logic [7:0] thresh,
  input  logic       bypass,
  output logic       sync,
  output logic       gpi
);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = 8'd0;
    end else if (thresh == 8'd0) begin
      filt_d = sync2_q;
      cnt_d  = 8'd0;
    end else if (tick) begin
      // A lowered threshold below a live count commits on this tick.
      if (cnt_inc >= {1'b0, thresh}) begin
        filt_d = sync2_q;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= pad;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync = sync2_q;
  assign gpi  = bypass ? sync2_q : filt_q;

endmodule

// File: rtl/reflet_ro_register.sv
// Generic 8-bit read-only bus register exposing an externally supplied value.
module reflet_ro_register #(
  parameter int unsigned          addr_size = 3,
  parameter logic [addr_size-1:0] reg_addr  = '0
) (
  input  logic                 enable,
  input  logic [addr_size-1:0] addr,
  input  logic [7:0]           content,
  output logic [7:0]           data_out
);

  assign data_out = (enable && (addr == reg_addr)) ? content : 8'h00;

endmodule

// File: rtl/reflet_rw_register.sv
// Generic 8-bit read/write bus register; read data is zero unless selected.
module reflet_rw_register #(
  parameter int unsigned             addr_size     = 3,
  parameter logic [addr_size-1:0]    reg_addr      = '0,
  parameter logic [7:0]              default_value = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [addr_size-1:0] addr,
  input  logic                 write_en,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic [7:0]           content
);

  logic hit;
  assign hit      = enable && (addr == reg_addr);
  assign data_out = hit ? content : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      content <= default_value;
    end else if (hit && write_en) begin
      content <= data_in;
    end
  end

endmodule

// File: rtl/reflet_gpi_debouncer.sv
// 16-input synchroniser/debouncer with memory-mapped prescaler, threshold and bypass.
module reflet_gpi_debouncer
  import reflet_gpi_debouncer_pkg::*;
#(
  parameter int unsigned               wordsize       = 16,
  parameter int unsigned               base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF08,
  parameter logic [15:0]               default_presc  = 16'd999,
  parameter logic [7:0]                default_thresh = 8'd8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [15:0]               pad_in,
  output logic [15:0]               gpi_out
);

  logic [base_addr_size-1:0] offset;
  logic                      sel;
  logic [2:0]                reg_addr;
  logic [7:0]                wdata;
  logic                      unused_data_hi;

  // Unsigned wrap makes addresses below base_addr fall outside the window too.
  assign offset         = addr - base_addr;
  assign sel            = enable && (offset < base_addr_size'(REG_COUNT));
  assign reg_addr       = offset[2:0];
  assign wdata          = data_in[7:0];
  assign unused_data_hi = ^data_in[wordsize-1:8];

  logic [7:0]  presc_lo, presc_hi, thresh, bypass_lo, bypass_hi;
  logic [7:0]  rd_presc_lo, rd_presc_hi, rd_thresh, rd_bypass_lo, rd_bypass_hi;
  logic [7:0]  rd_sync_lo, rd_sync_hi;
  logic [15:0] sync, bypass, presc;

  reflet_rw_register #(.addr_size(3), .reg_addr(PRESC_LO), .default_value(default_presc[7:0]))
    u_presc_lo (.clk(clk), .reset(reset), .enable(sel), .addr(reg_addr), .write_en(write_en),
                .data_in(wdata), .data_out(rd_presc_lo), .content(presc_lo));
  reflet_rw_register #(.addr_size(3), .reg_addr(PRESC_HI), .default_value(default_presc[15:8]))
    u_presc_hi (.clk(clk), .reset(reset), .enable(sel), .addr(reg_addr), .write_en(write_en),
                .data_in(wdata), .data_out(rd_presc_hi), .content(presc_hi));
  reflet_rw_register #(.addr_size(3), .reg_addr(THRESH), .default_value(default_thresh))
    u_thresh (.clk(clk), .reset(reset), .enable(sel), .addr(reg_addr), .write_en(write_en),
              .data_in(wdata), .data_out(rd_thresh), .content(thresh));
  reflet_rw_register #(.addr_size(3), .reg_addr(BYPASS_LO), .default_value(8'h00))
    u_bypass_lo (.clk(clk), .reset(reset), .enable(sel), .addr(reg_addr), .write_en(write_en),
                 .data_in(wdata), .data_out(rd_bypass_lo), .content(bypass_lo));
  reflet_rw_register #(.addr_size(3), .reg_addr(BYPASS_HI), .default_value(8'h00))
    u_bypass_hi (.clk(clk), .reset(reset), .enable(sel), .addr(reg_addr), .write_en(write_en),
                 .data_in(wdata), .data_out(rd_bypass_hi), .content(bypass_hi));
  reflet_ro_register #(.addr_size(3), .reg_addr(SYNC_LO))
    u_sync_lo (.enable(sel), .addr(reg_addr), .content(sync[7:0]), .data_out(rd_sync_lo));
  reflet_ro_register #(.addr_size(3), .reg_addr(SYNC_HI))
    u_sync_hi (.enable(sel), .addr(reg_addr), .content(sync[15:8]), .data_out(rd_sync_hi));

  assign presc  = {presc_hi, presc_lo};
  assign bypass = {bypass_hi, bypass_lo};
  assign data_out = {{(wordsize - 8){1'b0}},
                     rd_presc_lo | rd_presc_hi | rd_thresh | rd_bypass_lo | rd_bypass_hi |
                     rd_sync_lo | rd_sync_hi};

  // Tick prescaler; a PRESC write restarts the period but the current tick still reaches filters.
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        tick, presc_wr;

  assign presc_wr = sel && write_en && ((reg_addr == PRESC_LO) || (reg_addr == PRESC_HI));
  assign tick     = (tick_cnt_q == presc);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 16'd1;
    if (presc_wr || tick) begin
      tick_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_bit
    reflet_debounce_bit u_bit (
      .clk    (clk),
      .reset  (reset),
      .pad    (pad_in[i]),
      .tick   (tick),
      .thresh (thresh),
      .bypass (bypass[i]),
      .sync   (sync[i]),
      .gpi    (gpi_out[i])
    );
  end

endmodule

// File: tb/tb_reflet_gpi_debouncer.sv
// Self-checking bench: directed scenarios plus randomized pads/config against a behavioural model.
module tb_reflet_gpi_debouncer;

  localparam logic [15:0] BASE = 16'hFF08;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        write_en = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic [15:0] pad_in = 16'h0000;
  logic [15:0] gpi_out;

  int n_checks = 0;
  int n_errors = 0;

  reflet_gpi_debouncer dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .pad_in   (pad_in),
    .gpi_out  (gpi_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: pad history, register file, cycles since period start, ticks seen per bit.
  logic [15:0] m_p1, m_sync, m_filt, m_bypass, m_presc;
  logic [7:0]  m_thresh;
  int          m_phase;
  int          m_ticks[16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_sync = '0; m_filt = '0; m_bypass = '0;
    m_presc = 16'd999; m_thresh = 8'd8; m_phase = 0;
    for (int i = 0; i < 16; i++) m_ticks[i] = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] off);
    case (off)
      16'd0: return m_presc[7:0];
      16'd1: return m_presc[15:8];
      16'd2: return m_thresh;
      16'd3: return m_bypass[7:0];
      16'd4: return m_bypass[15:8];
      16'd5: return m_sync[7:0];
      16'd6: return m_sync[15:8];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] exp_gpi();
    return (m_bypass & m_sync) | (~m_bypass & m_filt);
  endfunction

  task automatic model_step();
    bit          tick, wr;
    logic [15:0] off;
    if (!reset) begin
      model_reset();
      return;
    end
    tick = (m_phase == int'(m_presc));
    for (int i = 0; i < 16; i++) begin
      if (m_sync[i] == m_filt[i]) begin
        m_ticks[i] = 0;
      end else if (m_thresh == 0) begin
        m_filt[i] = m_sync[i];
        m_ticks[i] = 0;
      end else if (tick) begin
        m_ticks[i]++;
        if (m_ticks[i] >= int'(m_thresh)) begin
          m_filt[i] = m_sync[i];
          m_ticks[i] = 0;
        end
      end
    end
    off = addr - BASE;
    wr  = enable && write_en && (off < 16'd8);
    if ((wr && off < 16'd2) || tick) m_phase = 0;
    else m_phase++;
    if (wr) begin
      case (off)
        16'd0: m_presc[7:0]   = data_in[7:0];
        16'd1: m_presc[15:8]  = data_in[7:0];
        16'd2: m_thresh       = data_in[7:0];
        16'd3: m_bypass[7:0]  = data_in[7:0];
        16'd4: m_bypass[15:8] = data_in[7:0];
        default: ;
      endcase
    end
    m_sync = m_p1;
    m_p1   = pad_in;
  endtask

  // One clock: model follows the posedge, gpi_out is compared at the negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("gpi_model", {16'h0, gpi_out}, {16'h0, exp_gpi()});
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] val);
    enable = 1'b1; write_en = 1'b1; addr = BASE + 16'(off); data_in = {8'hC3, val};
    cycle();
    enable = 1'b0; write_en = 1'b0; data_in = 16'h0000;
  endtask

  task automatic read_addr(input string tag, input logic [15:0] a, input logic en);
    logic [15:0] off;
    off = a - BASE;
    enable = en; write_en = 1'b0; addr = a;
    #1;
    check_eq(tag, {16'h0, data_out},
             {16'h0, ((en && off < 16'd8) ? {8'h00, model_read(off)} : 16'h0000)});
    enable = 1'b0;
  endtask

  task automatic read_const(input string tag, input logic [2:0] off, input logic [7:0] exp);
    enable = 1'b1; write_en = 1'b0; addr = BASE + 16'(off);
    #1;
    check_eq(tag, {16'h0, data_out}, {24'h0, exp});
    enable = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] pads);
    reset = 1'b0; pad_in = pads; enable = 1'b0; write_en = 1'b0;
    model_reset();
    #1;
    check_eq("rst_gpi", {16'h0, gpi_out}, 32'h0);
    check_eq("rst_dout", {16'h0, data_out}, 32'h0);
    cycle(); cycle();
    reset = 1'b1;
  endtask

  initial begin
    int k;
    bit seen;
    model_reset();
    @(negedge clk);

    // Reset values and first-step latency with PRESC=0, THRESH=3.
    do_reset(16'h0000);
    read_const("rst_presc_lo", 3'd0, 8'hE7);
    read_const("rst_presc_hi", 3'd1, 8'h03);
    read_const("rst_thresh", 3'd2, 8'h08);
    read_const("rst_bypass", 3'd3, 8'h00);
    bus_write(3'd0, 8'h00); bus_write(3'd1, 8'h00); bus_write(3'd2, 8'h03);
    pad_in = 16'hFFFF;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      check_eq("step_early", {16'h0, gpi_out}, 32'h0);
    end
    cycle();
    check_eq("step_done", {16'h0, gpi_out}, 32'hFFFF);
    read_const("sync_lo", 3'd5, 8'hFF);
    read_const("sync_hi", 3'd6, 8'hFF);

    // Bounce rejection on bit 0.
    do_reset(16'h0000);
    bus_write(3'd0, 8'h03); bus_write(3'd1, 8'h00); bus_write(3'd2, 8'h04);
    for (int c = 0; c < 60; c++) begin
      if (c % 6 == 0) pad_in[0] = ~pad_in[0];
      cycle();
      check_eq("bounce_hold", {31'h0, gpi_out[0]}, 32'h0);
    end
    pad_in[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 18 && !seen; c++) begin
      cycle();
      seen = gpi_out[0];
    end
    check_eq("bounce_rise", {31'h0, seen}, 32'h1);

    // Bypass on bit 0 only.
    do_reset(16'h0000);
    bus_write(3'd3, 8'h01);
    pad_in[1:0] = 2'b11;
    cycle();
    check_eq("byp_e1", {30'h0, gpi_out[1:0]}, 32'h0);
    pad_in[1:0] = 2'b00;
    cycle();
    check_eq("byp_e2", {30'h0, gpi_out[1:0]}, 32'h1);
    cycle();
    check_eq("byp_e3", {30'h0, gpi_out[1:0]}, 32'h0);
    for (int c = 0; c < 10; c++) cycle();
    check_eq("byp_bit1", {31'h0, gpi_out[1]}, 32'h0);

    // Register readback and decode boundaries.
    bus_write(3'd0, 8'hA5); bus_write(3'd1, 8'h00); bus_write(3'd2, 8'h02);
    bus_write(3'd3, 8'h0F); bus_write(3'd4, 8'hF0);
    read_const("rb_0", 3'd0, 8'hA5);
    read_const("rb_1", 3'd1, 8'h00);
    read_const("rb_2", 3'd2, 8'h02);
    read_const("rb_3", 3'd3, 8'h0F);
    read_const("rb_4", 3'd4, 8'hF0);
    read_const("rb_7", 3'd7, 8'h00);
    enable = 1'b0; addr = BASE; #1;
    check_eq("rb_disabled", {16'h0, data_out}, 32'h0);
    enable = 1'b1; addr = BASE + 16'd8; #1;
    check_eq("rb_above", {16'h0, data_out}, 32'h0);
    addr = BASE - 16'd1; #1;
    check_eq("rb_below", {16'h0, data_out}, 32'h0);
    enable = 1'b0;

    // Threshold 0 is pure synchroniser latency.
    do_reset(16'h0000);
    bus_write(3'd0, 8'hFF); bus_write(3'd1, 8'hFF); bus_write(3'd2, 8'h00);
    pad_in[15] = 1'b1;
    cycle(); cycle();
    check_eq("t0_e2", {31'h0, gpi_out[15]}, 32'h0);
    cycle();
    check_eq("t0_e3", {31'h0, gpi_out[15]}, 32'h1);

    // Asynchronous reset in the middle of a long count.
    do_reset(16'h0000);
    bus_write(3'd0, 8'h00); bus_write(3'd1, 8'h00); bus_write(3'd2, 8'd200);
    pad_in[3] = 1'b1;
    for (int c = 0; c < 100; c++) cycle();
    check_eq("arst_pre", {31'h0, gpi_out[3]}, 32'h0);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check_eq("arst_gpi", {16'h0, gpi_out}, 32'h0);
    #1 reset = 1'b1;
    bus_write(3'd2, 8'd200); bus_write(3'd0, 8'h00); bus_write(3'd1, 8'h00);
    k = 3;
    seen = 1'b0;
    while (k < 260 && !seen) begin
      cycle();
      k++;
      seen = gpi_out[3];
    end
    check_eq("arst_relatency", {31'h0, (seen && k >= 200 && k <= 205)}, 32'h1);

    // Randomized pads and configuration against the model.
    do_reset(16'h0000);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) bus_write(3'd0, 8'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) bus_write(3'd1, 8'h00);
      if ($urandom_range(0, 2) == 0) bus_write(3'd2, 8'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) bus_write(3'($urandom_range(3, 4)), 8'($urandom));
      for (int c = 0; c < 60; c++) begin
        pad_in = pad_in ^ 16'($urandom & $urandom & $urandom & $urandom);
        cycle();
      end
      read_addr("rnd_read", BASE - 16'd2 + 16'($urandom_range(0, 11)), 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
